// File: rtl/seq_detector_param_if.sv
// Symbol/pattern bus of the parametrised sequence detector.
// The master side drives symbols and pattern loads; the slave (the detector)
// returns the match pulse, the saturating match count and its saturation flag.
interface seq_detector_param_if #(
    parameter int SYM_W   = 2,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic                     in_valid;
    logic [SYM_W-1:0]         sym_in;
    logic                     overlap;
    logic                     pat_load;
    logic [SYM_W*PAT_LEN-1:0] pat_in;
    logic                     z;
    logic [CNT_W-1:0]         match_cnt;
    logic                     cnt_sat;

    modport master (
        output in_valid, sym_in, overlap, pat_load, pat_in,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  in_valid, sym_in, overlap, pat_load, pat_in,
        output z, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised multi-bit-per-cycle sequence detector.
// Keeps the last PAT_LEN accepted symbols, compares them (including the symbol
// arriving this cycle) against a runtime-loadable pattern, and raises a
// registered one-cycle pulse on a match. Overlapping or non-overlapping
// detection is selected per cycle; matches are counted with saturation.
module seq_detector_param #(
    parameter int                         SYM_W   = 2,
    parameter int                         PAT_LEN = 4,
    parameter int                         CNT_W   = 8,
    parameter logic [SYM_W*PAT_LEN-1:0]   RST_PAT = 8'hB4
) (
    input  logic                  clk,
    input  logic                  clr,
    seq_detector_param_if.slave   bus
);
    localparam int PW     = SYM_W * PAT_LEN;
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [PW-1:0]     pattern_r;
    logic [PW-1:0]     hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              z_r;
    logic [CNT_W-1:0]  match_cnt_r;
    logic              cnt_sat_r;

    logic              accept_s;
    logic [PW-1:0]     cand_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              match_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    logic [PW-1:0]     pattern_nxt_s;
    logic [PW-1:0]     hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic              z_nxt_s;
    logic [CNT_W-1:0]  match_cnt_nxt_s;
    logic              cnt_sat_nxt_s;

    // Match evaluation: a load in the same cycle discards the symbol entirely.
    always_comb begin
        accept_s   = bus.in_valid & ~bus.pat_load;
        cand_s     = {hist_r[PW-SYM_W-1:0], bus.sym_in};
        fill_inc_s = fill_r;
        if (!accept_s) begin
            fill_inc_s = fill_r;
        end else if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
        match_s   = accept_s && (fill_inc_s == FILL_FULL) && (cand_s == pattern_r);
        cnt_inc_s = match_cnt_r;
        if (match_s && (match_cnt_r != CNT_ONES)) begin
            cnt_inc_s = match_cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = match_cnt_r;
        end
    end

    // Next-state selection: load flushes, accepted symbols shift, idles hold.
    always_comb begin
        pattern_nxt_s   = pattern_r;
        hist_nxt_s      = hist_r;
        fill_nxt_s      = fill_r;
        z_nxt_s         = 1'b0;
        match_cnt_nxt_s = match_cnt_r;
        cnt_sat_nxt_s   = cnt_sat_r;
        if (bus.pat_load) begin
            pattern_nxt_s   = bus.pat_in;
            fill_nxt_s      = FILL_ZERO;
            match_cnt_nxt_s = CNT_ZERO;
            cnt_sat_nxt_s   = 1'b0;
        end else if (accept_s) begin
            hist_nxt_s      = cand_s;
            // Non-overlapping mode demands PAT_LEN fresh symbols after a hit.
            fill_nxt_s      = (match_s && !bus.overlap) ? FILL_ZERO : fill_inc_s;
            z_nxt_s         = match_s;
            match_cnt_nxt_s = cnt_inc_s;
            cnt_sat_nxt_s   = (cnt_inc_s == CNT_ONES);
        end else begin
            z_nxt_s = 1'b0;
        end
    end

    // State and output registers with immediate clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pattern_r   <= RST_PAT;
            hist_r      <= {PW{1'b0}};
            fill_r      <= FILL_ZERO;
            z_r         <= 1'b0;
            match_cnt_r <= CNT_ZERO;
            cnt_sat_r   <= 1'b0;
        end else begin
            pattern_r   <= pattern_nxt_s;
            hist_r      <= hist_nxt_s;
            fill_r      <= fill_nxt_s;
            z_r         <= z_nxt_s;
            match_cnt_r <= match_cnt_nxt_s;
            cnt_sat_r   <= cnt_sat_nxt_s;
        end
    end

    assign bus.z         = z_r;
    assign bus.match_cnt = match_cnt_r;
    assign bus.cnt_sat   = cnt_sat_r;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default-width instance and a
// CNT_W=3 instance share one stimulus stream; expected values are hand-derived.
module tb_seq_detector_param;
    logic clk;
    logic clr;
    int   total;
    int   passed;

    seq_detector_param_if #(.SYM_W(2), .PAT_LEN(4), .CNT_W(8)) bus ();
    seq_detector_param_if #(.SYM_W(2), .PAT_LEN(4), .CNT_W(3)) bus3 ();

    assign bus3.in_valid = bus.in_valid;
    assign bus3.sym_in   = bus.sym_in;
    assign bus3.overlap  = bus.overlap;
    assign bus3.pat_load = bus.pat_load;
    assign bus3.pat_in   = bus.pat_in;

    seq_detector_param #(.SYM_W(2), .PAT_LEN(4), .CNT_W(8), .RST_PAT(8'hB4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    seq_detector_param #(.SYM_W(2), .PAT_LEN(4), .CNT_W(3), .RST_PAT(8'hB4)) dut3 (
        .clk (clk),
        .clr (clr),
        .bus (bus3.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic v, input logic [1:0] s);
        bus.in_valid = v;
        bus.sym_in   = s;
        bus.pat_load = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic v, input logic [1:0] s);
        bus.in_valid = v;
        bus.sym_in   = s;
        bus.pat_load = 1'b1;
        bus.pat_in   = p;
        @(posedge clk);
        #1;
        bus.pat_load = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    logic [1:0] seq_b4 [4];
    logic [1:0] seq_33 [6];

    initial begin
        total         = 0;
        passed        = 0;
        seq_b4        = '{2'd2, 2'd3, 2'd1, 2'd0};
        seq_33        = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        clr           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sym_in    = 2'd0;
        bus.overlap   = 1'b1;
        bus.pat_load  = 1'b0;
        bus.pat_in    = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        chk("rst_sat", 32'(bus.cnt_sat), 32'd0);
        clr = 1'b0;

        // T1: default pattern, back-to-back.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq_b4[i]);
            chk($sformatf("t1_z_%0d", i), 32'(bus.z), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t1_cnt", 32'(bus.match_cnt), 32'd1);
        step(1'b0, 2'd0);
        chk("t1_z_after", 32'(bus.z), 32'd0);

        // T2a: pattern 0,3,0,3 overlapping.
        load(8'h33, 1'b0, 2'd0);
        chk("t2_load_cnt", 32'(bus.match_cnt), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq_33[i]);
            chk($sformatf("t2o_z_%0d", i), 32'(bus.z), (i == 3 || i == 5) ? 32'd1 : 32'd0);
        end
        chk("t2o_cnt", 32'(bus.match_cnt), 32'd2);

        // T2b: same pattern, non-overlapping.
        bus.overlap = 1'b0;
        load(8'h33, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq_33[i]);
            chk($sformatf("t2n_z_%0d", i), 32'(bus.z), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t2n_cnt", 32'(bus.match_cnt), 32'd1);
        bus.overlap = 1'b1;

        // T3: idle gaps of 1..3 cycles between symbols; sym_in garbage while idle.
        load(8'hB4, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq_b4[i]);
            chk($sformatf("t3_z_%0d", i), 32'(bus.z), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) begin
                for (int g = 0; g <= i; g++) begin
                    step(1'b0, 2'd0);
                    chk($sformatf("t3_idle_%0d_%0d", i, g), 32'(bus.z), 32'd0);
                end
            end
        end
        chk("t3_cnt", 32'(bus.match_cnt), 32'd1);
        step(1'b0, 2'd0);
        chk("t3_z_after", 32'(bus.z), 32'd0);

        // T4: load mid-sequence flushes; the symbol sent with the load is discarded.
        load(8'hB4, 1'b0, 2'd0);
        step(1'b1, 2'd2);
        step(1'b1, 2'd3);
        load(8'hB4, 1'b1, 2'd1);
        chk("t4_load_z", 32'(bus.z), 32'd0);
        step(1'b1, 2'd1);
        step(1'b1, 2'd0);
        chk("t4_flush_z", 32'(bus.z), 32'd0);
        chk("t4_flush_cnt", 32'(bus.match_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, seq_b4[i]);
        chk("t4_match_z", 32'(bus.z), 32'd1);
        chk("t4_cnt", 32'(bus.match_cnt), 32'd1);

        // T5: counter saturation on the 3-bit instance.
        load(8'hB4, 1'b0, 2'd0);
        for (int k = 1; k <= 9; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, seq_b4[i]);
            chk($sformatf("t5_cnt3_%0d", k), 32'(bus3.match_cnt), (k > 7) ? 32'd7 : 32'(k));
            chk($sformatf("t5_sat3_%0d", k), 32'(bus3.cnt_sat), (k >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("t5_cnt8_%0d", k), 32'(bus.match_cnt), 32'(k));
        end
        chk("t5_sat8", 32'(bus.cnt_sat), 32'd0);
        load(8'hB4, 1'b0, 2'd0);
        chk("t5_load_cnt3", 32'(bus3.match_cnt), 32'd0);
        chk("t5_load_sat3", 32'(bus3.cnt_sat), 32'd0);

        // T6: asynchronous clear mid-stream restores the reset pattern and history.
        load(8'h33, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) step(1'b1, seq_33[i]);
        chk("t6_pre_z", 32'(bus.z), 32'd1);
        chk("t6_pre_cnt", 32'(bus.match_cnt), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, seq_b4[i]);
        for (int i = 0; i < 3; i++) step(1'b1, seq_b4[i]);
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, seq_33[i]);
        end
        chk("t6_pre_sat3", 32'(bus3.cnt_sat), 32'd1);
        step(1'b1, 2'd2);
        step(1'b1, 2'd3);
        step(1'b1, 2'd1);
        #2;
        clr = 1'b1;
        #1;
        chk("t6_clr_z", 32'(bus.z), 32'd0);
        chk("t6_clr_cnt", 32'(bus.match_cnt), 32'd0);
        chk("t6_clr_sat3", 32'(bus3.cnt_sat), 32'd0);
        chk("t6_clr_cnt3", 32'(bus3.match_cnt), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        step(1'b1, 2'd0);
        chk("t6_post0_z", 32'(bus.z), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, seq_b4[i]);
        chk("t6_rst_pat_z", 32'(bus.z), 32'd1);
        chk("t6_rst_pat_cnt", 32'(bus.match_cnt), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
